// File: rtl/alu_result_collector.sv
// Tagged result collector behind the four-unit ALU: priority select, format, FIFO, handshake out.
// Optional RESULT_PARITY_EN adds a per-entry even-parity bit, OUT_PARITY and sticky PAR_ERR.
module alu_result_collector #(
    parameter int IN_DATA_WIDTH = 16,
    parameter int RES_WIDTH     = 2 * IN_DATA_WIDTH,
    parameter int CMP_WIDTH     = 3,
    parameter int DEPTH         = 4,
    localparam int AW           = $clog2(DEPTH),
    localparam int CW           = AW + 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [RES_WIDTH-1:0]     Arith_OUT,
    input  logic                     Arith_Flag,
    input  logic                     Carry_OUT,
    input  logic [IN_DATA_WIDTH-1:0] Logic_OUT,
    input  logic                     Logic_Flag,
    input  logic [IN_DATA_WIDTH-1:0] SHIFT_OUT,
    input  logic                     SHIFT_Flag,
    input  logic [CMP_WIDTH-1:0]     CMP_OUT,
    input  logic                     CMP_Flag,
    output logic [RES_WIDTH-1:0]     OUT_DATA,
    output logic [1:0]               OUT_TAG,
    output logic                     OUT_CARRY,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [CW-1:0]            COUNT,
    input  logic                     CLR_ERR,
    output logic                     OVF_ERR,
`ifdef RESULT_PARITY_EN
    output logic                     OUT_PARITY,
    output logic                     PAR_ERR,
`endif
    output logic                     MULTI_ERR
);

    logic [CW-1:0]        wr_q, wr_d;
    logic [CW-1:0]        rd_q, rd_d;
    logic                 ovf_q, ovf_d;
    logic                 multi_q, multi_d;

    logic [RES_WIDTH-1:0] data_q  [DEPTH];
    logic [1:0]           tag_q   [DEPTH];
    logic                 carry_q [DEPTH];

    logic [RES_WIDTH-1:0] sel_data;
    logic [1:0]           sel_tag;
    logic                 sel_carry;

    logic                 push_req;
    logic                 multi_evt;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 push_ok;
    logic                 ovf_evt;
    logic [AW-1:0]        head;
    logic [AW-1:0]        tail;

    assign head = rd_q[AW-1:0];
    assign tail = wr_q[AW-1:0];

    assign push_req  = Arith_Flag | Logic_Flag | SHIFT_Flag | CMP_Flag;
    assign multi_evt = (Arith_Flag & (Logic_Flag | SHIFT_Flag | CMP_Flag))
                     | (Logic_Flag & (SHIFT_Flag | CMP_Flag))
                     | (SHIFT_Flag & CMP_Flag);

    // Fixed priority: arith, logic, shift, compare
    always_comb begin
        sel_data  = '0;
        sel_tag   = 2'd0;
        sel_carry = 1'b0;
        if (Arith_Flag) begin
            sel_data  = Arith_OUT;
            sel_tag   = 2'd0;
            sel_carry = Carry_OUT;
        end else if (Logic_Flag) begin
            sel_data  = RES_WIDTH'(Logic_OUT);
            sel_tag   = 2'd1;
        end else if (SHIFT_Flag) begin
            sel_data  = RES_WIDTH'(SHIFT_OUT);
            sel_tag   = 2'd2;
        end else if (CMP_Flag) begin
            sel_data  = RES_WIDTH'(CMP_OUT);
            sel_tag   = 2'd3;
        end
    end

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (tail == head);

    // Pop frees the head slot this edge, so a full FIFO can still accept
    assign pop     = ~empty & OUT_READY;
    assign push_ok = push_req & (~full | pop);
    assign ovf_evt = push_req & full & ~pop;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        ovf_d   = (ovf_q & ~CLR_ERR) | ovf_evt;
        multi_d = (multi_q & ~CLR_ERR) | multi_evt;
        if (push_ok) begin
            wr_d = wr_q + CW'(1);
        end
        if (pop) begin
            rd_d = rd_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
            multi_q <= multi_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            data_q[tail]  <= sel_data;
            tag_q[tail]   <= sel_tag;
            carry_q[tail] <= sel_carry;
        end
    end

    assign OUT_VALID = ~empty;
    assign OUT_DATA  = empty ? '0   : data_q[head];
    assign OUT_TAG   = empty ? 2'd0 : tag_q[head];
    assign OUT_CARRY = empty ? 1'b0 : carry_q[head];
    assign COUNT     = wr_q - rd_q;
    assign OVF_ERR   = ovf_q;
    assign MULTI_ERR = multi_q;

`ifdef RESULT_PARITY_EN
    logic par_q [DEPTH];
    logic par_err_q, par_err_d;
    logic head_par;
    logic par_evt;

    assign head_par = ^{OUT_TAG, OUT_CARRY, OUT_DATA};
    assign par_evt  = pop & (head_par != par_q[head]);
    assign par_err_d = (par_err_q & ~CLR_ERR) | par_evt;

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            par_q[tail] <= ^{sel_tag, sel_carry, sel_data};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign OUT_PARITY = empty ? 1'b0 : par_q[head];
    assign PAR_ERR    = par_err_q;
`endif

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Downstream stage of the four-unit ALU: samples the registered unit outputs and their valid flags every clock.
- Selects the active unit's result and formats it into one tagged, width-normalised word.
- Buffers results in a small FIFO and hands them to the consumer over a valid/ready handshake, so back-pressure never stalls the ALU.
- Reports dropped results (overflow) and illegal multi-flag cycles.

Parameters:
- IN_DATA_WIDTH, 16, ALU operand width.
- RES_WIDTH, 2*IN_DATA_WIDTH, normalised result data width (arith result is full width).
- CMP_WIDTH, 3, compare-unit output width.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- Arith_OUT  in  RES_WIDTH  signed arithmetic result.
- Arith_Flag  in  1  arithmetic result valid.
- Carry_OUT  in  1  arithmetic carry.
- Logic_OUT  in  IN_DATA_WIDTH  logic result.
- Logic_Flag  in  1  logic result valid.
- SHIFT_OUT  in  IN_DATA_WIDTH  shift result.
- SHIFT_Flag  in  1  shift result valid.
- CMP_OUT  in  CMP_WIDTH  compare result.
- CMP_Flag  in  1  compare result valid.
- OUT_DATA  out  RES_WIDTH  head-entry data.
- OUT_TAG  out  2  head-entry source: 0 arith, 1 logic, 2 shift, 3 cmp.
- OUT_CARRY  out  1  head-entry carry; 0 for non-arith entries.
- OUT_VALID  out  1  head entry present.
- OUT_READY  in  1  consumer accepts head.
- COUNT  out  log2(DEPTH)+1  entries stored.
- CLR_ERR  in  1  synchronous clear of the sticky error flags.
- OVF_ERR  out  1  sticky: a result was dropped.
- MULTI_ERR  out  1  sticky: more than one flag was high in one cycle.

Behaviour:
- Reset (RST=0, async): FIFO pointers, COUNT, OVF_ERR and MULTI_ERR go to 0; OUT_VALID=0. OUT_DATA, OUT_TAG and OUT_CARRY read 0. Reset mid-transfer discards all entries.
- Push request: any *_Flag high at a rising edge.
- Source priority: Arith > Logic > SHIFT > CMP. With two or more flags high, only the highest-priority result is pushed and MULTI_ERR sets.
- Formatting:
  - arith: data = Arith_OUT unchanged; carry = Carry_OUT.
  - logic/shift: zero-extended to RES_WIDTH.
  - cmp: zero-extended to RES_WIDTH.
  - carry = 0 for all non-arith sources.
- FIFO is show-ahead:
  - OUT_VALID = (COUNT != 0).
  - OUT_DATA, OUT_TAG and OUT_CARRY reflect the head combinationally from storage.
- Pop: OUT_VALID & OUT_READY at a rising edge. The head advances and the next entry appears in the same cycle the pop takes effect.
- Latency: a flag sampled at edge N makes OUT_VALID=1 after edge N (FIFO previously empty). Data is visible in cycle N+1.
- Full (COUNT=DEPTH):
  - Push without a simultaneous pop: result dropped, OVF_ERR sets, storage unchanged.
  - Push with a simultaneous pop: both accepted, COUNT stays DEPTH.
- Empty: OUT_READY is ignored and COUNT never underflows.
- Simultaneous push and pop when not full or empty: COUNT unchanged.
- Pointers: wrap modulo DEPTH, with an extra MSB to tell full from empty.
- CLR_ERR: clears both sticky flags at the edge. If a new error occurs in the same cycle, the error wins (the flag stays 1).
- Data-path rule: no combinational path from any input to OUT_VALID; the only one is OUT_READY → pop logic.

Optional Feature:
- RESULT_PARITY_EN defined:
  - Each entry stores an even-parity bit over {tag, carry, data}, computed at push.
  - Extra output OUT_PARITY (1 bit) presents the head's parity.
  - Extra sticky output PAR_ERR sets if the parity recomputed on the head at pop mismatches the stored bit; CLR_ERR clears it.
- Undefined: no parity storage; OUT_PARITY and PAR_ERR ports are absent.

Test Plan:
- Reset then Logic_Flag=1, Logic_OUT=16'hA5A5, OUT_READY=0 → next cycle OUT_VALID=1, OUT_DATA=32'h0000A5A5, OUT_TAG=1, OUT_CARRY=0, COUNT=1.
- Arith_Flag=1, Arith_OUT=-6 (32'hFFFFFFFA), Carry_OUT=1 → OUT_DATA=32'hFFFFFFFA, OUT_TAG=0, OUT_CARRY=1 (no truncation, no sign loss).
- Push 5 CMP results (CMP_OUT=1..5), OUT_READY=0, DEPTH=4 → COUNT=4, OVF_ERR=1. Then pop 4 → data 1,2,3,4 in order, then OUT_VALID=0.
- FIFO full, SHIFT_Flag=1 and OUT_READY=1 in the same cycle → no drop, OVF_ERR stays 0, COUNT=4, new entry emerges last.
- Arith_Flag=1 and CMP_Flag=1 together → one entry, tag 0; MULTI_ERR=1. CLR_ERR pulse → MULTI_ERR=0.
- Three entries stored, assert RST=0 mid-cycle → OUT_VALID=0 and COUNT=0 immediately (async), flags cleared, no stale entry after release.
